// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// One radix-2 step per cycle (shift-add multiply, restoring divide), then a sign-fix cycle.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Handshake: start is sampled at a rising edge only while busy==0; a MULT/DIV
  // accepted at that edge raises busy for WIDTH+1 cycles, and done pulses for the
  // single cycle after HI/LO are written (busy is already 0 in that cycle).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_mag, b_mag, a_raw;
  logic [WIDTH-1:0] work_hi, work_lo;
  logic             is_div, neg_q, neg_r;

  // Operand decode at acceptance
  logic             md_start, in_signed, in_a_neg, in_b_neg;
  logic [WIDTH-1:0] in_a_mag, in_b_mag;

  assign md_start  = (state == S_IDLE) && start && !op[2];
  assign in_signed = ~op[0];
  assign in_a_neg  = in_signed & op_a[WIDTH-1];
  assign in_b_neg  = in_signed & op_b[WIDTH-1];
  assign in_a_mag  = in_a_neg ? (~op_a + 1'b1) : op_a;
  assign in_b_mag  = in_b_neg ? (~op_b + 1'b1) : op_b;

  // Iteration datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_trial;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {2'b00, b_mag};
    div_ge    = ~div_trial[WIDTH+1];
  end

  // Sign correction; divide-by-zero returns all-ones quotient and the raw dividend
  always_comb begin
    prod_mag = {work_hi, work_lo};
    prod_fix = neg_q ? (~prod_mag + 1'b1) : prod_mag;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (b_mag == '0) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        fix_hi = neg_r ? (~work_hi + 1'b1) : work_hi;
        fix_lo = neg_q ? (~work_lo + 1'b1) : work_lo;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (md_start) next_state = S_CALC;
      S_CALC:  if (cnt == CW'(WIDTH - 1)) next_state = S_FIX;
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      cnt     <= '0;
      a_mag   <= '0;
      b_mag   <= '0;
      a_raw   <= '0;
      work_hi <= '0;
      work_lo <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      done <= (state == S_FIX);
      case (state)
        S_IDLE: begin
          if (start && op == 3'b100) hi <= op_a;
          if (start && op == 3'b101) lo <= op_a;
          if (md_start) begin
            cnt     <= '0;
            a_mag   <= in_a_mag;
            b_mag   <= in_b_mag;
            a_raw   <= op_a;
            is_div  <= op[1];
            neg_q   <= in_a_neg ^ in_b_neg;
            neg_r   <= in_a_neg;
            work_hi <= '0;
            work_lo <= op[1] ? in_a_mag : in_b_mag;
          end
        end
        S_CALC: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            work_hi <= div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            work_lo <= {work_lo[WIDTH-2:0], div_ge};
          end else begin
            work_hi <= mul_sum[WIDTH:1];
            work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: hand-computed HI/LO results, latency,
// done pulse, MTHI/MTLO, busy-ignore, back-to-back issue and async reset.
module tb_mips_muldiv_unit;

  logic        clk;
  logic        reset_n;
  logic [31:0] op_a, op_b;
  logic [2:0]  op;
  logic        start;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [1:0]  state_dbg;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_hi, cur_lo;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .op_a(op_a), .op_b(op_b), .op(op),
    .start(start), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a MULT/DIV, wait for completion, and check latency and result.
  task automatic run_md(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input bit inject_mthi);
    int n;
    exp_q.push_back(ehi);
    exp_q.push_back(elo);
    start = 1'b1; op = o; op_a = a; op_b = b;
    tick();
    start = 1'b0; op_a = ~a; op_b = ~b;
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    check({tag, " done_low_at_start"}, 32'(done), 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (inject_mthi && n == 5) begin
        start = 1'b1; op = 3'b100; op_a = 32'h1234_5678; op_b = 32'h0;
      end
      if (inject_mthi && n == 6) start = 1'b0;
      if (n == 16) begin
        check({tag, " hi_held"}, hi, cur_hi);
        check({tag, " lo_held"}, lo, cur_lo);
      end
      tick();
    end
    check({tag, " busy_cycles"}, 32'(n), 32'd33);
    check({tag, " done_pulse"}, 32'(done), 32'd1);
    check({tag, " hi"}, hi, exp_q.pop_front());
    check({tag, " lo"}, lo, exp_q.pop_front());
    cur_hi = ehi;
    cur_lo = elo;
    op = 3'b110;
  endtask

  task automatic move_to(input string tag, input logic [2:0] o, input logic [31:0] d);
    start = 1'b1; op = o; op_a = d; op_b = 32'h0;
    tick();
    start = 1'b0; op = 3'b110;
    check({tag, " busy"}, 32'(busy), 32'd0);
    if (o == 3'b100) cur_hi = d;
    if (o == 3'b101) cur_lo = d;
    check({tag, " hi"}, hi, cur_hi);
    check({tag, " lo"}, lo, cur_lo);
    tick();
    check({tag, " no_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    reset_n = 1'b0; start = 1'b0; op = 3'b110; op_a = '0; op_b = '0;
    cur_hi = '0; cur_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    check("rst state", 32'(state_dbg), 32'd0);
    reset_n = 1'b1;
    tick();

    // MTHI / MTLO from IDLE, then no-op op code
    move_to("mthi", 3'b100, 32'h1234_5678);
    move_to("mtlo", 3'b101, 32'hCAFE_F00D);
    move_to("nop", 3'b111, 32'hDEAD_BEEF);

    // Async reset in the middle of a DIVU
    start = 1'b1; op = 3'b011; op_a = 32'd100; op_b = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("midrst busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    cur_hi = '0; cur_lo = '0;
    tick();
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    check("midrst no_done", 32'(dones), 32'd0);
    check("midrst busy_after", 32'(busy), 32'd0);

    // Multiply
    run_md("mult_m2x3", 3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    run_md("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_md("mult_min2", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);

    // Divide, signs, zero divisor, overflow
    run_md("div_m7d2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_md("div_7dm2", 3'b010, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_md("div_m7dm2", 3'b010, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
    run_md("divu_7d0", 3'b011, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0);
    run_md("div_m5d0", 3'b010, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
    run_md("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

    // MTHI issued while busy is ignored
    run_md("mult_inj", 3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b1);

    // Back-to-back: DIVU issued in the done cycle of a MULT
    run_md("b2b_mult", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_md("b2b_divu", 3'b011, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0);

    // MTHI from IDLE afterwards takes effect
    move_to("mthi_idle", 3'b100, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
